pdp8_serial_mem: RTL
====================

PDP8_SERIAL_MEM -- requirements
Module: pdp8_serial_mem

Interface
REQ-001 Parameter WIDTH, default 12, is the word width in bits.
REQ-002 Parameter WORDS, default 128, is the memory depth; the word address is 7 bits wide.
REQ-003 Port sysclk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is the asynchronous active-high reset.
REQ-005 Port ma, input, 7, is the CPU word address.
REQ-006 Port ba, input, 4, is the CPU bit index within the word; only 0..11 are valid.
REQ-007 Port write, input, 1, is the CPU bit-write strobe.
REQ-008 Port mb, input, 1, is the CPU serial write-data bit.
REQ-009 Port halt, input, 1, is the CPU halted status.
REQ-010 Port membus, output, 1, is the serial read-data bit returned to the CPU.
REQ-011 Port contin, output, 1, is the continue pulse to the CPU.
REQ-012 Port ld_start, input, 1, is the host request to begin a program load.
REQ-013 Port ld_valid, input, 1, qualifies ld_bit.
REQ-014 Port ld_bit, input, 1, is the host serial load-data bit.
REQ-015 Port ld_ready, output, 1, indicates the block accepts load bits.
REQ-016 Port run_req, input, 1, is the host request to resume the CPU.
REQ-017 Port busy, output, 1, is high in LOAD and RUN.

Function
REQ-018 The block shall hold a WORDS x WIDTH bit-addressable array, state undefined after reset (not cleared).
REQ-019 The block shall register membus as mem[ma][ba] sampled at each edge: one-cycle latency, read-before-write on the same address.
REQ-020 The block shall register membus as 0 when ba > 11 or the state is LOAD.
REQ-021 The block shall write mem[ma][ba] <= mb when write=1, ba <= 11 and the state is not LOAD; otherwise the CPU write is ignored.
REQ-022 The FSM shall have four states: IDLE, LOAD, RUN, HALTED.
REQ-023 IDLE shall go to LOAD on ld_start; otherwise to HALTED if halt=1, else to RUN.
REQ-024 In LOAD, ld_ready shall be 1, and each cycle with ld_valid=1 shall write ld_bit to mem[lptr_w][lptr_b], then increment lptr_b.
REQ-025 At lptr_b=11, the load pointer shall wrap lptr_b to 0 and increment lptr_w; bits are LSB-first and words run 0..127.
REQ-026 After the write of bit 11 of word 127, the FSM shall leave LOAD for HALTED and clear both load pointers; no further load bits are accepted.
REQ-027 ld_start asserted during LOAD shall restart the pointers at word 0, bit 0 on the next cycle.
REQ-028 From HALTED, run_req=1 shall drive contin=1 for exactly one cycle and move the FSM to RUN.
REQ-029 In RUN, halt=1 shall move the FSM to HALTED; ld_start shall be honoured only in HALTED or IDLE.
REQ-030 In HALTED, if run_req and ld_start are both asserted, ld_start shall take priority.
REQ-031 contin shall be 0 in every state and cycle other than the REQ-028 pulse.
REQ-032 ld_ready shall be 0 outside LOAD, and ld_valid outside LOAD shall be ignored.

Reset
REQ-033 Reset shall asynchronously force the FSM to IDLE, membus=0, contin=0, ld_ready=0, busy=0, and both load pointers to 0.
REQ-034 Reset during LOAD shall abandon the load; words already written shall remain as written.

Structure
REQ-035 Package pdp8_mem_pkg shall hold WIDTH, WORDS, the address and bit-index widths, and the FSM state enum.
REQ-036 The array and its bit read/write port shall be one sub-module, pdp8_mem_array, with the write-select mux (loader vs CPU) and the FSM kept in pdp8_serial_mem.

Verification
REQ-037 Load test: load 1536 bits with word n = n XOR 0o5252 -> ld_ready drops after the last bit, FSM in HALTED, CPU read of ma=3, ba=0..11 returns 0o5251 LSB-first, each bit one cycle after its address.
REQ-038 Write test: write=1, ma=10, ba=4, mb=1, then read ma=10, ba=4 -> membus=0 (old value) the same cycle, 1 on the following read.
REQ-039 Bit-index bounds: ba=12..15 with write=1 -> membus=0 and the array is unchanged.
REQ-040 Continue test: FSM in HALTED, 3-cycle run_req -> exactly one contin pulse, FSM in RUN; halt=1 -> HALTED, busy=0.
REQ-041 Reset mid-load: reset asserted after 100 load bits -> immediate IDLE with ld_ready=0; words 0..7 hold loaded data; word 8 bits 0..3 hold loaded data.
REQ-042 Priority: ld_start and run_req high together in HALTED -> LOAD entered, contin stays 0.

Source files
------------

// File: rtl/pdp8_mem_pkg.sv
// Shared definitions for the PDP-8 serial bit memory.
//   MEM_WIDTH / MEM_WORDS : default word width and memory depth
//   ADDR_W / BIT_W        : word-address and bit-index widths
//   state_t               : controller states (IDLE, LOAD, RUN, HALTED)
package pdp8_mem_pkg;

  localparam int MEM_WIDTH = 12;
  localparam int MEM_WORDS = 128;
  localparam int ADDR_W    = 7;
  localparam int BIT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/pdp8_mem_array.sv
// Bit-addressable WORDS x WIDTH storage with one bit write port and one
// registered bit read port.
//   sysclk, reset : clock and asynchronous active-high reset (read register only)
//   we, waddr, wbit, wdata : single-bit write
//   raddr, rbit   : read address and bit index
//   rmask         : forces the registered read bit to 0 for this cycle
//   rdata         : registered read bit, one cycle after its address
// The storage itself has no reset, so contents survive a reset.
module pdp8_mem_array
  import pdp8_mem_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH,
  parameter int WORDS = MEM_WORDS
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BIT_W-1:0]  wbit,
  input  logic              wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [BIT_W-1:0]  rbit,
  input  logic              rmask,
  output logic              rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge sysclk) begin
    if (we) begin
      mem[waddr][wbit] <= wdata;
    end
  end

  // Non-blocking read sees the pre-write contents: read-before-write.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rdata <= 1'b0;
    end else if (rmask) begin
      rdata <= 1'b0;
    end else begin
      rdata <= mem[raddr][rbit];
    end
  end

endmodule

// File: rtl/pdp8_serial_mem.sv
// Serial bit memory for a bit-serial PDP-8 CPU with a host program loader.
//   sysclk, reset        : clock, asynchronous active-high reset
//   ma, ba, write, mb    : CPU word address, bit index, bit-write strobe, write bit
//   halt                 : CPU halted status
//   membus               : registered read bit mem[ma][ba] (0 in LOAD or ba > 11)
//   contin               : one-cycle continue pulse when leaving HALTED on run_req
//   ld_start             : host request to (re)start a load at word 0, bit 0
//   ld_valid, ld_bit     : host load bit and its qualifier
//   ld_ready             : high in LOAD only
//   run_req              : host request to resume the CPU
//   busy                 : high in LOAD and RUN
//   fsm_state            : current controller state, for observation
//
// Load handshake: a load bit is transferred on a rising edge where
// ld_valid and ld_ready are both 1 and ld_start is 0. ld_start in LOAD
// takes precedence and only rewinds the pointers; its bit is dropped.
module pdp8_serial_mem
  import pdp8_mem_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH,
  parameter int WORDS = MEM_WORDS
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ma,
  input  logic [BIT_W-1:0]  ba,
  input  logic              write,
  input  logic              mb,
  input  logic              halt,
  output logic              membus,
  output logic              contin,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_bit,
  output logic              ld_ready,
  input  logic              run_req,
  output logic              busy,
  output state_t            fsm_state
);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lptr_w_q, lptr_w_d;
  logic [BIT_W-1:0]  lptr_b_q, lptr_b_d;
  logic              contin_q, contin_d;
  logic              ld_we;

  logic              in_load;
  logic              cpu_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [BIT_W-1:0]  mem_wbit;
  logic              mem_wdata;
  logic              rd_mask;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lptr_w_q <= '0;
      lptr_b_q <= '0;
      contin_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lptr_w_q <= lptr_w_d;
      lptr_b_q <= lptr_b_d;
      contin_q <= contin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lptr_w_d = lptr_w_q;
    lptr_b_d = lptr_b_q;
    contin_d = 1'b0;
    ld_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d  = ST_LOAD;
          lptr_w_d = '0;
          lptr_b_d = '0;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_start) begin
          lptr_w_d = '0;
          lptr_b_d = '0;
        end else if (ld_valid) begin
          ld_we = 1'b1;
          if (lptr_b_q == LAST_BIT) begin
            lptr_b_d = '0;
            if (lptr_w_q == LAST_WORD) begin
              // Final bit of the final word: load complete.
              state_d  = ST_HALTED;
              lptr_w_d = '0;
            end else begin
              lptr_w_d = lptr_w_q + 1'b1;
            end
          end else begin
            lptr_b_d = lptr_b_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (ld_start) begin
          state_d  = ST_LOAD;
          lptr_w_d = '0;
          lptr_b_d = '0;
        end else if (run_req) begin
          state_d  = ST_RUN;
          contin_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The loader owns the write port for the whole of LOAD; CPU writes are
  // dropped there, and out-of-range bit indices never write.
  assign in_load   = (state_q == ST_LOAD);
  assign cpu_we    = write && (ba <= LAST_BIT) && !in_load;
  assign mem_we    = in_load ? ld_we    : cpu_we;
  assign mem_waddr = in_load ? lptr_w_q : ma;
  assign mem_wbit  = in_load ? lptr_b_q : ba;
  assign mem_wdata = in_load ? ld_bit   : mb;
  assign rd_mask   = (ba > LAST_BIT) || in_load;

  pdp8_mem_array #(
    .WIDTH (WIDTH),
    .WORDS (WORDS)
  ) u_array (
    .sysclk (sysclk),
    .reset  (reset),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wbit   (mem_wbit),
    .wdata  (mem_wdata),
    .raddr  (ma),
    .rbit   (ba),
    .rmask  (rd_mask),
    .rdata  (membus)
  );

  assign contin    = contin_q;
  assign ld_ready  = in_load;
  assign busy      = in_load || (state_q == ST_RUN);
  assign fsm_state = state_q;

endmodule
